// File: rtl/leitor_amostras_pwm.sv
// Sample reader and PWM player: once per sample period it fetches one byte
// from audio memory at the address given by the address generator, latches
// it as the playing sample, pulses count to advance the generator, and
// drives the speaker with an 8-bit free-running PWM.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   enable    play (1) / pause (0)
//   endereco  current sample address from the address generator
//   mem_req   read request, held until ack or timeout
//   mem_addr  address of the pending read, stable while mem_req=1
//   mem_ack   one-cycle read-complete strobe, mem_data valid with it
//   mem_data  read data
//   count     one-cycle pulse advancing the address generator
//   sample    sample currently playing
//   pwm_out   PWM audio output
//   underrun  sticky: sample tick arrived while a read was still in flight
//   mem_err   sticky: a read timed out
module leitor_amostras_pwm #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SAMPLE_DIV  = 1134,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] endereco,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              count,
  output logic [DATA_W-1:0] sample,
  output logic              pwm_out,
  output logic              underrun,
  output logic              mem_err
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned TO_W  = $clog2(MEM_TIMEOUT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ADV  = 2'd2
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] pwm_cnt;
  logic              tick_c;

  // Sample-rate strobe; pausing suppresses it in the same cycle.
  assign tick_c = enable && (div_cnt == DIV_LAST);

  // Sample-rate divider, read FSM, sticky flags and PWM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      to_cnt   <= '0;
      pwm_cnt  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      count    <= 1'b0;
      sample   <= MIDSCALE;
      pwm_out  <= 1'b0;
      underrun <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      if (!enable || (div_cnt == DIV_LAST)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Compare against the sample as it stands now; no period alignment.
      pwm_cnt <= pwm_cnt + DATA_W'(1);
      pwm_out <= (pwm_cnt < sample);

      count <= 1'b0;

      // A tick that finds a read in flight is dropped but remembered.
      if (tick_c && (state != IDLE)) begin
        underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick_c) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= endereco;
            to_cnt   <= '0;
          end else if (!enable) begin
            sample <= MIDSCALE;
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            sample  <= mem_data;
            state   <= ADV;
            mem_req <= 1'b0;
            count   <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ADV: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_amostras_pwm.sv
// Bench for leitor_amostras_pwm: directed scenarios plus a randomized run,
// with a behavioural player model checked against every output each cycle.
module tb_leitor_amostras_pwm;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 8;
  localparam int unsigned SD = 300;
  localparam int unsigned MT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] endereco;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          count;
  logic [DW-1:0] sample;
  logic          pwm_out;
  logic          underrun;
  logic          mem_err;

  leitor_amostras_pwm #(
    .ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(SD), .MEM_TIMEOUT(MT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .endereco(endereco),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .count(count), .sample(sample),
    .pwm_out(pwm_out), .underrun(underrun), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Activity counters over measurement windows (cleared by the stimulus).
  int cnt_req   = 0;
  int cnt_pulse = 0;
  int cnt_pwm   = 0;

  // Memory responder configuration.
  int            ack_delay = 0;  // 0 = never acknowledge
  int            req_age   = 0;
  bit            fixed_en  = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  int            stray_pct = 0;
  bit            force_ack = 1'b0;

  // Reference model: one optional pending read plus the player's state.
  bit            m_busy, m_pulse, m_pwm, m_under, m_err;
  int            m_wait, m_div, m_pwm_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_sample;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : ref_model
    bit tick;
    if (!reset) begin
      m_busy = 0; m_pulse = 0; m_wait = 0; m_addr = '0; m_sample = 8'h80;
      m_pwm = 0; m_pwm_cnt = 0; m_div = 0; m_under = 0; m_err = 0;
    end else begin
      tick      = enable && (m_div == SD - 1);
      m_div     = enable ? (m_div + 1) % SD : 0;
      m_pwm     = (m_pwm_cnt < int'(m_sample));
      m_pwm_cnt = (m_pwm_cnt + 1) % 256;
      if (m_busy || m_pulse) begin
        if (tick) m_under = 1;
        if (m_pulse) begin
          m_pulse = 0;
        end else if (mem_ack) begin
          m_sample = mem_data;
          m_busy   = 0;
          m_pulse  = 1;
        end else begin
          m_wait++;
          if (m_wait == MT) begin
            m_busy = 0;
            m_err  = 1;
          end
        end
      end else if (tick) begin
        m_busy = 1;
        m_addr = endereco;
        m_wait = 0;
      end else if (!enable) begin
        m_sample = 8'h80;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req",  32'(mem_req),  32'(m_busy));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("count",    32'(count),    32'(m_pulse));
      check("sample",   32'(sample),   32'(m_sample));
      check("pwm_out",  32'(pwm_out),  32'(m_pwm));
      check("underrun", 32'(underrun), 32'(m_under));
      check("mem_err",  32'(mem_err),  32'(m_err));
      cnt_req   += int'(mem_req);
      cnt_pulse += int'(count);
      cnt_pwm   += int'(pwm_out);
    end
  end

  task automatic clear_counts();
    cnt_req = 0; cnt_pulse = 0; cnt_pwm = 0;
  endtask

  // Memory side: ack after a programmable delay, optional stray acks.
  task automatic drive_mem();
    mem_ack = 1'b0;
    if (mem_req) begin
      req_age++;
      if (ack_delay != 0 && req_age == ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = fixed_en ? fixed_val : DW'($urandom);
      end
    end else begin
      req_age = 0;
      if (stray_pct != 0 && int'($urandom_range(99)) < stray_pct) begin
        mem_ack  = 1'b1;
        mem_data = DW'($urandom);
      end
    end
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_data  = 8'hA5;
      force_ack = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_mem();
    end
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!mem_req && n < budget) begin
      step(1);
      n++;
    end
    if (!mem_req) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_req no mem_req within %0d cycles", n);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0; enable = 1'b0; endereco = '0; mem_ack = 1'b0; mem_data = '0;
    step(3);
    chk_en = 1'b1;

    // Reset values.
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_sample",   32'(sample),   32'h80);
    check("rst_pwm_out",  32'(pwm_out),  32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_mem_err",  32'(mem_err),  32'd0);

    // Normal playback, ack after 3 cycles with data C0.
    reset = 1'b1; enable = 1'b1; endereco = 22'd1000;
    ack_delay = 3; fixed_en = 1'b1; fixed_val = 8'hC0;
    wait_req(400, n);
    check("first_req_cycle", 32'(n), 32'd300);
    endereco = 22'd77;
    step(1);
    check("addr_held", 32'(mem_addr), 32'd1000);
    step(10);
    check("sample_c0", 32'(sample), 32'hC0);
    check("model_c0",  32'(m_sample), 32'hC0);
    clear_counts();
    step(600);
    check("pulses_600", 32'(cnt_pulse), 32'd2);
    clear_counts();
    step(256);
    check("pwm_hi_c0", 32'(cnt_pwm), 32'd192);

    // Memory never acknowledges: one 16-cycle request, then mem_err.
    pulse_reset();
    ack_delay = 0;
    clear_counts();
    step(330);
    check("to_req_cycles", 32'(cnt_req), 32'd16);
    check("to_mem_err",    32'(mem_err), 32'd1);
    check("to_pulses",     32'(cnt_pulse), 32'd0);
    check("to_sample",     32'(sample), 32'h80);

    // Very slow memory: every read times out before the next tick.
    pulse_reset();
    ack_delay = 320;
    clear_counts();
    step(650);
    check("slow_req_cycles", 32'(cnt_req), 32'd32);
    check("slow_pulses",     32'(cnt_pulse), 32'd0);
    check("slow_underrun",   32'(underrun), 32'd0);

    // Pause while a read is pending: it completes, then silence.
    pulse_reset();
    ack_delay = 3; fixed_val = 8'h10;
    wait_req(400, n);
    enable = 1'b0;
    clear_counts();
    step(400);
    check("pause_pulses",    32'(cnt_pulse), 32'd1);
    check("pause_req_cycles", 32'(cnt_req), 32'd3);
    check("pause_sample",    32'(sample), 32'h80);
    enable = 1'b1;
    wait_req(400, n);
    check("resume_req_cycle", 32'(n), 32'd300);

    // Reset in the middle of a request; a late ack is ignored.
    step(1);
    reset = 1'b0; ack_delay = 0; force_ack = 1'b1;
    step(1);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_pwm",     32'(pwm_out), 32'd0);
    reset = 1'b1;
    step(1);
    check("late_ack_req",    32'(mem_req),  32'd0);
    check("late_ack_count",  32'(count),    32'd0);
    check("late_ack_sample", 32'(sample),   32'h80);
    check("late_ack_addr",   32'(mem_addr), 32'd0);
    check("late_ack_under",  32'(underrun), 32'd0);
    check("late_ack_err",    32'(mem_err),  32'd0);

    // PWM extremes.
    pulse_reset();
    ack_delay = 2; fixed_val = 8'h00;
    step(320);
    clear_counts();
    step(256);
    check("pwm_hi_00", 32'(cnt_pwm), 32'd0);
    fixed_val = 8'hFF;
    step(44);
    clear_counts();
    step(256);
    check("pwm_hi_ff", 32'(cnt_pwm), 32'd255);

    // Randomized traffic: addresses, ack delays around the timeout,
    // stray acks, pauses and occasional resets.
    fixed_en = 1'b0; stray_pct = 5;
    for (int i = 0; i < 6000; i++) begin
      endereco = AW'($urandom);
      if ($urandom_range(399) == 0) enable = ~enable;
      if (!mem_req) ack_delay = ($urandom_range(3) == 0) ? 16 : int'($urandom_range(20, 1));
      reset = ($urandom_range(1999) != 0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
